// File: rtl/reg_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_scoreboard: per-GPR pending-write counters between ID issue and WB;    |
// | raises a decode stall on RAW hazards and on destination-counter saturation.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module reg_scoreboard #(
  parameter int NREG      = 32,  // at most 32, addresses are 5 bits
  parameter int CNT_W     = 3,
  parameter int WB_BYPASS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ds_valid,
  input  logic       ds_src1_used,
  input  logic [4:0] ds_src1_addr,
  input  logic       ds_src2_used,
  input  logic [4:0] ds_src2_addr,
  input  logic       ds_gr_we,
  input  logic [4:0] ds_dest,
  input  logic       ds_issue,
  input  logic       ws_rf_we,
  input  logic [4:0] ws_rf_waddr,
  input  logic       flush,
  output logic       ds_raw_stall,
  output logic       sb_busy,
  output logic       sb_err
);

  localparam int               c_nslot   = 32;
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam bit               c_bypass  = (WB_BYPASS != 0);

  // Slots 0 and >= NREG exist only so 5-bit addresses index safely; they stay 0.
  logic [CNT_W-1:0]   r_cnt [c_nslot];
  logic               r_err;
  logic [c_nslot-1:0] w_inc;
  logic [c_nslot-1:0] w_dec;
  logic               w_err_set;
  logic               w_src1_pend;
  logic               w_src2_pend;
  logic               w_dest_full;
  logic               w_any;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 1; i < c_nslot; i++) begin
      w_inc[i] = ds_issue && ds_gr_we && (ds_dest == 5'(i));
      w_dec[i] = ws_rf_we && (ws_rf_waddr == 5'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < c_nslot; i++) begin
      if (reset || flush || i == 0 || i >= NREG) begin
        r_cnt[i] <= '0;
      end else if (w_inc[i] && !w_dec[i]) begin
        r_cnt[i] <= r_cnt[i] + c_cnt_one;
      end else if (w_dec[i] && !w_inc[i] && r_cnt[i] != '0) begin
        r_cnt[i] <= r_cnt[i] - c_cnt_one;
      end
    end
  end

  // A retire with nothing outstanding is only an error when no flush or matching issue absorbs it.
  assign w_err_set = ws_rf_we && (ws_rf_waddr != 5'd0) && !flush &&
                     !w_inc[ws_rf_waddr] && (r_cnt[ws_rf_waddr] == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  // The last outstanding write retiring this cycle no longer blocks a reader when bypass is on.
  assign w_src1_pend = ds_src1_used && (ds_src1_addr != 5'd0) && (r_cnt[ds_src1_addr] != '0) &&
                       !(c_bypass && w_dec[ds_src1_addr] && r_cnt[ds_src1_addr] == c_cnt_one);
  assign w_src2_pend = ds_src2_used && (ds_src2_addr != 5'd0) && (r_cnt[ds_src2_addr] != '0) &&
                       !(c_bypass && w_dec[ds_src2_addr] && r_cnt[ds_src2_addr] == c_cnt_one);
  assign w_dest_full = ds_gr_we && (ds_dest != 5'd0) && (r_cnt[ds_dest] == c_cnt_max);

  assign ds_raw_stall = ds_valid && (w_src1_pend || w_src2_pend || w_dest_full);

  always_comb begin
    w_any = 1'b0;
    for (int i = 0; i < c_nslot; i++) begin
      w_any = w_any | (r_cnt[i] != '0);
    end
  end

  assign sb_busy = w_any;
  assign sb_err  = r_err;

  a_no_issue_on_stall : assert property (@(posedge clk) disable iff (reset)
    !(ds_issue && ds_raw_stall))
    else $error("reg_scoreboard: ds_issue asserted while ds_raw_stall");

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reg_scoreboard: directed vector table plus randomized traffic on three   |
// | scoreboard configurations, checked against an integer reference model.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_reg_scoreboard;

  typedef struct {
    bit       rst, v, s1u;
    bit [4:0] s1;
    bit       s2u;
    bit [4:0] s2;
    bit       we;
    bit [4:0] d;
    bit       iss, wwe;
    bit [4:0] wa;
    bit       fl;
    bit       st0, st1, st2, busy, err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, ds_valid, ds_src1_used, ds_src2_used, ds_gr_we, ws_rf_we, flush;
  logic [4:0] ds_src1_addr, ds_src2_addr, ds_dest, ws_rf_waddr;
  logic       iss [3];
  logic       st  [3];
  logic       bz  [3];
  logic       er  [3];

  int nchk = 0;
  int nerr = 0;

  // Reference model: plain integer pending counts per configuration.
  // Index 0: bypass, 3-bit; 1: no bypass, 3-bit; 2: bypass, 2-bit.
  int mc [3][32];
  bit me [3];
  int cmax [3] = '{7, 7, 3};
  bit bp   [3] = '{1'b1, 1'b0, 1'b1};

  vec_t tbl [37];

  always #5 clk = ~clk;

  reg_scoreboard #(.NREG(32), .CNT_W(3), .WB_BYPASS(1)) dut_main (
    .clk(clk), .reset(reset), .ds_valid(ds_valid),
    .ds_src1_used(ds_src1_used), .ds_src1_addr(ds_src1_addr),
    .ds_src2_used(ds_src2_used), .ds_src2_addr(ds_src2_addr),
    .ds_gr_we(ds_gr_we), .ds_dest(ds_dest), .ds_issue(iss[0]),
    .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr), .flush(flush),
    .ds_raw_stall(st[0]), .sb_busy(bz[0]), .sb_err(er[0]));

  reg_scoreboard #(.NREG(32), .CNT_W(3), .WB_BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .ds_valid(ds_valid),
    .ds_src1_used(ds_src1_used), .ds_src1_addr(ds_src1_addr),
    .ds_src2_used(ds_src2_used), .ds_src2_addr(ds_src2_addr),
    .ds_gr_we(ds_gr_we), .ds_dest(ds_dest), .ds_issue(iss[1]),
    .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr), .flush(flush),
    .ds_raw_stall(st[1]), .sb_busy(bz[1]), .sb_err(er[1]));

  reg_scoreboard #(.NREG(32), .CNT_W(2), .WB_BYPASS(1)) dut_c2 (
    .clk(clk), .reset(reset), .ds_valid(ds_valid),
    .ds_src1_used(ds_src1_used), .ds_src1_addr(ds_src1_addr),
    .ds_src2_used(ds_src2_used), .ds_src2_addr(ds_src2_addr),
    .ds_gr_we(ds_gr_we), .ds_dest(ds_dest), .ds_issue(iss[2]),
    .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr), .flush(flush),
    .ds_raw_stall(st[2]), .sb_busy(bz[2]), .sb_err(er[2]));

  function automatic vec_t mk(int rst, int v, int s1u, int s1, int s2u, int s2, int we, int d,
                              int is, int wwe, int wa, int fl,
                              int e0, int e1, int e2, int eb, int ee);
    vec_t m;
    m.rst = rst[0]; m.v = v[0]; m.s1u = s1u[0]; m.s1 = s1[4:0];
    m.s2u = s2u[0]; m.s2 = s2[4:0]; m.we = we[0]; m.d = d[4:0];
    m.iss = is[0]; m.wwe = wwe[0]; m.wa = wa[4:0]; m.fl = fl[0];
    m.st0 = e0[0]; m.st1 = e1[0]; m.st2 = e2[0]; m.busy = eb[0]; m.err = ee[0];
    return m;
  endfunction

  function automatic bit m_pend(int k, logic [4:0] a);
    return (a != 0) && (mc[k][a] != 0) &&
           !(bp[k] && ws_rf_we && ws_rf_waddr == a && mc[k][a] == 1);
  endfunction

  function automatic bit m_stall(int k);
    return ds_valid && ((ds_src1_used && m_pend(k, ds_src1_addr)) ||
                        (ds_src2_used && m_pend(k, ds_src2_addr)) ||
                        (ds_gr_we && ds_dest != 0 && mc[k][ds_dest] == cmax[k]));
  endfunction

  function automatic bit m_busy(int k);
    int s = 0;
    for (int r = 0; r < 32; r++) s += mc[k][r];
    return s != 0;
  endfunction

  task automatic m_clock();
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        for (int r = 0; r < 32; r++) mc[k][r] = 0;
        me[k] = 1'b0;
      end else if (flush) begin
        for (int r = 0; r < 32; r++) mc[k][r] = 0;
      end else begin
        bit inc = iss[k] && ds_gr_we && ds_dest != 0;
        bit dec = ws_rf_we && ws_rf_waddr != 0;
        if (!(inc && dec && ds_dest == ws_rf_waddr)) begin
          if (inc) mc[k][ds_dest]++;
          if (dec) begin
            if (mc[k][ws_rf_waddr] > 0) mc[k][ws_rf_waddr]--;
            else me[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check(string name, int act, int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Inputs are already driven; compare in the low phase, then clock the model with the DUTs.
  task automatic run_cycle(bit has_exp, vec_t e);
    #1;
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("model_stall[%0d]", k), int'(st[k]), int'(m_stall(k)));
        check($sformatf("model_busy[%0d]", k),  int'(bz[k]), int'(m_busy(k)));
        check($sformatf("model_err[%0d]", k),   int'(er[k]), int'(me[k]));
      end
      if (has_exp) begin
        check("tbl_stall_byp",  int'(st[0]), int'(e.st0));
        check("tbl_stall_nob",  int'(st[1]), int'(e.st1));
        check("tbl_stall_cw2",  int'(st[2]), int'(e.st2));
        check("tbl_busy",       int'(bz[0]), int'(e.busy));
        check("tbl_err",        int'(er[0]), int'(e.err));
      end
    end
    @(posedge clk);
    m_clock();
    @(negedge clk);
  endtask

  initial begin
    vec_t none;
    none = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    // rst v s1u s1 s2u s2 we d iss wwe wa fl | st_byp st_nob st_cw2 busy err
    tbl[0]  = mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[1]  = mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[2]  = mk(0,1,0,0,0,0,1,5,1,0,0,0, 0,0,0,0,0);
    tbl[3]  = mk(0,1,1,5,0,0,0,0,0,0,0,0, 1,1,1,1,0);
    tbl[4]  = mk(0,1,1,5,0,0,0,0,0,0,0,0, 1,1,1,1,0);
    tbl[5]  = mk(0,1,1,5,0,0,0,0,0,1,5,0, 0,1,0,1,0);
    tbl[6]  = mk(0,1,1,5,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[7]  = mk(0,1,0,0,0,0,1,7,1,0,0,0, 0,0,0,0,0);
    tbl[8]  = mk(0,1,0,0,0,0,1,7,1,0,0,0, 0,0,0,1,0);
    tbl[9]  = mk(0,1,0,0,0,0,1,7,1,0,0,0, 0,0,0,1,0);
    tbl[10] = mk(0,1,1,7,0,0,0,0,0,0,0,0, 1,1,1,1,0);
    tbl[11] = mk(0,1,1,7,0,0,0,0,0,1,7,0, 1,1,1,1,0);
    tbl[12] = mk(0,1,1,7,0,0,0,0,0,1,7,0, 1,1,1,1,0);
    tbl[13] = mk(0,1,1,7,0,0,0,0,0,1,7,0, 0,1,0,1,0);
    tbl[14] = mk(0,1,1,7,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[15] = mk(0,1,0,0,0,0,1,9,1,0,0,0, 0,0,0,0,0);
    tbl[16] = mk(0,1,0,0,0,0,1,9,1,1,9,0, 0,0,0,1,0);
    tbl[17] = mk(0,1,0,0,1,9,0,0,0,0,0,0, 1,1,1,1,0);
    tbl[18] = mk(0,1,0,0,1,9,0,0,0,1,9,0, 0,1,0,1,0);
    tbl[19] = mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[20] = mk(0,1,1,0,1,0,1,0,1,0,0,0, 0,0,0,0,0);
    tbl[21] = mk(0,1,1,0,1,0,1,0,1,1,0,0, 0,0,0,0,0);
    tbl[22] = mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[23] = mk(0,1,0,0,0,0,1,4,1,0,0,0, 0,0,0,0,0);
    tbl[24] = mk(0,1,0,0,0,0,1,4,1,0,0,1, 0,0,0,1,0);
    tbl[25] = mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[26] = mk(0,0,0,0,0,0,0,0,0,1,4,0, 0,0,0,0,0);
    tbl[27] = mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1);
    tbl[28] = mk(0,1,1,4,0,0,0,0,0,0,0,0, 0,0,0,0,1);
    tbl[29] = mk(0,1,0,0,0,0,1,3,1,0,0,0, 0,0,0,0,1);
    tbl[30] = mk(0,1,0,0,0,0,1,3,1,0,0,0, 0,0,0,1,1);
    tbl[31] = mk(0,1,0,0,0,0,1,3,1,0,0,0, 0,0,0,1,1);
    tbl[32] = mk(0,1,0,0,0,0,1,3,0,0,0,0, 0,0,1,1,1);
    tbl[33] = mk(0,1,0,0,0,0,1,3,0,1,3,0, 0,0,1,1,1);
    tbl[34] = mk(0,1,0,0,0,0,1,3,1,0,0,0, 0,0,0,1,1);
    tbl[35] = mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[36] = mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);

    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 32; r++) mc[k][r] = 0;
      me[k] = 1'b0;
    end

    for (int i = 0; i < 37; i++) begin
      reset        = tbl[i].rst;
      ds_valid     = tbl[i].v;
      ds_src1_used = tbl[i].s1u;
      ds_src1_addr = tbl[i].s1;
      ds_src2_used = tbl[i].s2u;
      ds_src2_addr = tbl[i].s2;
      ds_gr_we     = tbl[i].we;
      ds_dest      = tbl[i].d;
      ws_rf_we     = tbl[i].wwe;
      ws_rf_waddr  = tbl[i].wa;
      flush        = tbl[i].fl;
      for (int k = 0; k < 3; k++) iss[k] = tbl[i].iss;
      run_cycle(1'b1, tbl[i]);
    end

    // Random traffic over a small register window so hazards, retires and saturation are frequent.
    for (int n = 0; n < 800; n++) begin
      bit want;
      reset        = ($urandom_range(0, 199) == 0);
      ds_valid     = ($urandom_range(0, 3) != 0);
      ds_src1_used = $urandom_range(0, 1) != 0;
      ds_src1_addr = 5'($urandom_range(0, 7));
      ds_src2_used = $urandom_range(0, 1) != 0;
      ds_src2_addr = 5'($urandom_range(0, 7));
      ds_gr_we     = ($urandom_range(0, 3) != 0);
      ds_dest      = 5'($urandom_range(0, 7));
      ws_rf_we     = $urandom_range(0, 1) != 0;
      ws_rf_waddr  = 5'($urandom_range(0, 7));
      flush        = ($urandom_range(0, 39) == 0);
      want         = $urandom_range(0, 1) != 0;
      for (int k = 0; k < 3; k++) iss[k] = want && ds_valid && !m_stall(k);
      run_cycle(1'b0, none);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
